// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock, WIDTH steps per divide.
// Divide-by-zero short-cuts to a one-cycle result of Q=all ones, Rem=dividend.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Rem,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ZERO = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] aq_q, aq_d;
  logic [WIDTH-1:0] bd_q, bd_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [2*WIDTH:0] step;

  // One restoring step; result is {next P, next Aq}. The shifted value is kept
  // one bit wider than P so the compare sees every bit, while the difference is
  // always below the divisor and fits back into P.
  function automatic logic [2*WIDTH:0] restore_step(
    input logic [WIDTH:0]   p,
    input logic [WIDTH-1:0] aq,
    input logic [WIDTH-1:0] bd
  );
    logic [WIDTH+1:0] sh;
    logic [WIDTH:0]   diff;
    sh   = {p, aq[WIDTH-1]};
    diff = sh[WIDTH:0] - {1'b0, bd};
    if (sh >= {2'b00, bd}) begin
      restore_step = {diff, aq[WIDTH-2:0], 1'b1};
    end else begin
      restore_step = {sh[WIDTH:0], aq[WIDTH-2:0], 1'b0};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aq_d    = aq_q;
    bd_d    = bd_q;
    p_d     = p_q;
    q_d     = q_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    step    = restore_step(p_q, aq_q, bd_q);

    case (state_q)
      IDLE: begin
        if (Start) begin
          aq_d    = A;
          bd_d    = B;
          p_d     = '0;
          cnt_d   = CNT_W'(WIDTH);
          busy_d  = 1'b1;
          state_d = (B == '0) ? ZERO : CALC;
        end
      end
      CALC: begin
        p_d   = step[2*WIDTH:WIDTH];
        aq_d  = step[WIDTH-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          q_d     = step[WIDTH-1:0];
          rem_d   = step[2*WIDTH-1:WIDTH];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      ZERO: begin
        // Dividend is still held in the partial-quotient register.
        q_d     = '1;
        rem_d   = aq_q;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      aq_q    <= '0;
      bd_q    <= '0;
      p_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aq_q    <= aq_d;
      bd_q    <= bd_d;
      p_q     <= p_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Q         = q_q;
  assign Rem       = rem_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;

endmodule
